// File: rtl/huff_sym_decode_if.sv
// Bus bundle for huff_sym_decode.
//   Table write stream : tbl_winc, tbl_addr, tbl_sym, tbl_len, tbl_done
//   Compressed bytes   : in_data, in_valid, in_last, in_ready
//   Decoded symbols    : sym_out, sym_len, sym_last, sym_valid, sym_ready
//   Status             : err
// The master modport is the side that feeds tables/bytes and accepts symbols;
// the slave modport is the decoder.
interface huff_sym_decode_if #(
    parameter int HUFF_CODE_LEN = 8,
    parameter int HUFF_LEN_LEN  = 4,
    parameter int SYM_W         = 8
);
    logic                     tbl_winc;
    logic [HUFF_CODE_LEN-1:0] tbl_addr;
    logic [SYM_W-1:0]         tbl_sym;
    logic [HUFF_LEN_LEN-1:0]  tbl_len;
    logic                     tbl_done;

    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;

    logic [SYM_W-1:0]         sym_out;
    logic [HUFF_LEN_LEN-1:0]  sym_len;
    logic                     sym_last;
    logic                     sym_valid;
    logic                     sym_ready;

    logic                     err;

    modport master (
        output tbl_winc, tbl_addr, tbl_sym, tbl_len, tbl_done,
        output in_data, in_valid, in_last,
        input  in_ready,
        input  sym_out, sym_len, sym_last, sym_valid,
        output sym_ready,
        input  err
    );

    modport slave (
        input  tbl_winc, tbl_addr, tbl_sym, tbl_len, tbl_done,
        input  in_data, in_valid, in_last,
        output in_ready,
        output sym_out, sym_len, sym_last, sym_valid,
        input  sym_ready,
        output err
    );
endinterface

// File: rtl/huff_sym_decode.sv
// Huffman symbol decoder.
// Captures a lookup table written by the table generator (one entry per
// left-justified code address), then, after tbl_done, pulls compressed bytes
// into a 16-bit LSB-first bit buffer, looks up the next HUFF_CODE_LEN stream
// bits (oldest bit is the address MSB) and emits one symbol per handshake,
// consuming exactly the code length.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous pulse: invalidate table, flush buffer, clear err, go to LOAD
//   bus    - huff_sym_decode_if.slave: table writes, byte input, symbol output, err
module huff_sym_decode #(
    parameter int HUFF_CODE_LEN = 8,
    parameter int HUFF_LEN_LEN  = 4,
    parameter int SYM_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    huff_sym_decode_if.slave    bus
);
    localparam int DEPTH = 1 << HUFF_CODE_LEN;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {LOAD, FILL, LOOKUP, OUT, ERR} state_t;

    state_t state, state_nxt;

    logic [SYM_W-1:0]        ram_sym [DEPTH];
    logic [HUFF_LEN_LEN-1:0] ram_len [DEPTH];
    logic [DEPTH-1:0]        ram_vld;

    logic [SYM_W-1:0]        rd_sym;
    logic [HUFF_LEN_LEN-1:0] rd_len;
    logic                    rd_vld;

    logic [15:0]             bit_buf;
    logic [CNT_W-1:0]        count;
    logic                    last_seen;
    logic                    run;
    logic                    err_q;

    logic [HUFF_CODE_LEN-1:0] window;
    logic                    in_ready_int;
    logic                    accept;
    logic                    code_ok;
    logic                    sym_valid_int;
    logic                    consume;
    logic [15:0]             buf_shift;
    logic [15:0]             buf_nxt;
    logic [CNT_W-1:0]        cnt_shift;
    logic [CNT_W-1:0]        cnt_nxt;

    // run holds in_ready low during reset and the first cycle after release.
    assign in_ready_int  = run & (count <= CNT_W'(8)) & ~last_seen & (state != ERR);
    assign accept        = bus.in_valid & in_ready_int;
    assign code_ok       = rd_vld & (CNT_W'(rd_len) <= count);
    assign sym_valid_int = (state == OUT) & code_ok;
    assign consume       = sym_valid_int & bus.sym_ready;

    // Oldest buffered bit is the address MSB; bits not yet received read as 0.
    always_comb begin
        window = '0;
        for (int unsigned k = 0; k < HUFF_CODE_LEN; k++) begin
            if (CNT_W'(k) < count) begin
                window[HUFF_CODE_LEN-1-k] = bit_buf[k];
            end
        end
    end

    // Consume first, then append the new byte right above the remaining bits.
    always_comb begin
        buf_shift = consume ? (bit_buf >> rd_len) : bit_buf;
        cnt_shift = consume ? (count - CNT_W'(rd_len)) : count;
        buf_nxt   = buf_shift;
        cnt_nxt   = cnt_shift;
        if (accept) begin
            buf_nxt = buf_shift | ({8'b0, bus.in_data} << cnt_shift);
            cnt_nxt = cnt_shift + CNT_W'(8);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_buf   <= '0;
            count     <= '0;
            last_seen <= 1'b0;
            run       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (clr) begin
                bit_buf   <= '0;
                count     <= '0;
                last_seen <= 1'b0;
            end else begin
                bit_buf <= buf_nxt;
                count   <= cnt_nxt;
                if (accept && bus.in_last) begin
                    last_seen <= 1'b1;
                end
            end
        end
    end

    // Table storage: data array has no reset, validity is tracked separately.
    always_ff @(posedge clk) begin
        if (bus.tbl_winc && !clr) begin
            ram_sym[bus.tbl_addr] <= bus.tbl_sym;
            ram_len[bus.tbl_addr] <= bus.tbl_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_vld <= '0;
        end else if (clr) begin
            ram_vld <= '0;
        end else if (bus.tbl_winc) begin
            ram_vld[bus.tbl_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sym <= '0;
            rd_len <= '0;
            rd_vld <= 1'b0;
        end else if (state == LOOKUP) begin
            rd_sym <= ram_sym[window];
            rd_len <= ram_len[window];
            rd_vld <= ram_vld[window];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if ((state == OUT) && !code_ok) begin
            err_q <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:   if (bus.tbl_done) state_nxt = FILL;
            FILL:   if ((count >= CNT_W'(8)) || (last_seen && (count != '0))) state_nxt = LOOKUP;
            LOOKUP: state_nxt = OUT;
            OUT: begin
                if (!code_ok) begin
                    state_nxt = ERR;
                end else if (bus.sym_ready) begin
                    state_nxt = FILL;
                end
            end
            ERR:    state_nxt = ERR;
            default: state_nxt = LOAD;
        endcase
        if (clr) begin
            state_nxt = LOAD;
        end
    end

    // FSM: outputs (symbol fields forced to zero whenever no symbol is offered)
    always_comb begin
        bus.in_ready  = in_ready_int;
        bus.sym_valid = sym_valid_int;
        bus.sym_out   = sym_valid_int ? rd_sym : '0;
        bus.sym_len   = sym_valid_int ? rd_len : '0;
        bus.sym_last  = sym_valid_int & last_seen & (count == CNT_W'(rd_len)) & ~accept;
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_huff_sym_decode.sv
// Self-checking bench for huff_sym_decode: a bit-level reference decoder fills
// an expected-symbol queue; a monitor compares every offered symbol.
module tb_huff_sym_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    huff_sym_decode_if #(.HUFF_CODE_LEN(8), .HUFF_LEN_LEN(4), .SYM_W(8)) bus ();

    huff_sym_decode #(.HUFF_CODE_LEN(8), .HUFF_LEN_LEN(4), .SYM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sym;
        logic [3:0] len;
        bit         last;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         hold_low = 1'b1;

    // Code book: right-aligned code value, length, symbol.
    logic [7:0] lv[$];
    int         ll[$];
    logic [7:0] ls[$];
    logic [7:0] bytes[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bus.sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.sym_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every offered symbol must equal the head of the queue
    // (also while stalled); pop on handshake.
    always @(negedge clk) begin
        if (rst_n && bus.sym_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_sym: got sym=%0d len=%0d, expected no symbol",
                         bus.sym_out, bus.sym_len);
            end else begin
                if (bus.sym_out !== q[0].sym || bus.sym_len !== q[0].len ||
                    bus.sym_last !== q[0].last) begin
                    n_fail++;
                    $display("FAIL sym: got sym=%0d len=%0d last=%0d expected sym=%0d len=%0d last=%0d",
                             bus.sym_out, bus.sym_len, bus.sym_last,
                             q[0].sym, q[0].len, q[0].last);
                end
                if (bus.sym_ready) void'(q.pop_front());
            end
        end
    end

    task automatic clear_leaves();
        lv.delete(); ll.delete(); ls.delete();
    endtask

    task automatic add_leaf(input logic [7:0] v, input int l, input logic [7:0] s);
        lv.push_back(v); ll.push_back(l); ls.push_back(s);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
    endtask

    // Every address whose top len bits equal the code maps to that entry.
    task automatic write_table();
        foreach (lv[i]) begin
            for (int f = 0; f < (1 << (8 - ll[i])); f++) begin
                bus.tbl_winc = 1'b1;
                bus.tbl_addr = 8'((int'(lv[i]) << (8 - ll[i])) | f);
                bus.tbl_sym  = ls[i];
                bus.tbl_len  = 4'(ll[i]);
                @(posedge clk); #1;
            end
        end
        bus.tbl_winc = 1'b0;
    endtask

    task automatic start();
        bus.tbl_done = 1'b1;
        @(posedge clk); #1;
        bus.tbl_done = 1'b0;
    endtask

    // Reference: walk the stream as a list of bits, prefix-match the code book.
    task automatic model_push(output bit e);
        bit bits[$];
        int pos;
        int total;
        foreach (bytes[i]) for (int j = 0; j < 8; j++) bits.push_back(bytes[i][j]);
        e = 1'b0;
        pos = 0;
        total = bits.size();
        while (pos < total) begin
            logic [7:0] w;
            int hit;
            w = '0;
            hit = -1;
            for (int k = 0; k < 8; k++) if (pos + k < total) w[7-k] = bits[pos+k];
            foreach (lv[i]) if (int'(w >> (8 - ll[i])) == int'(lv[i])) hit = i;
            if (hit < 0 || ll[hit] > total - pos) begin
                e = 1'b1;
                break;
            end
            q.push_back('{ls[hit], 4'(ll[hit]), (pos + ll[hit] == total)});
            pos += ll[hit];
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n = 0;
        bus.in_data  = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                break;
            end
            if (bus.err) break;
            n++;
            if (n > 500) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic send_all();
        foreach (bytes[i]) send_byte(bytes[i], i == bytes.size() - 1);
    endtask

    task automatic wait_sym_valid();
        int n = 0;
        while (!bus.sym_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("sym_valid_seen", int'(bus.sym_valid), 1);
    endtask

    task automatic finish_check(input bit e, input string name);
        int n = 0;
        while ((q.size() != 0 || (e && !bus.err)) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) chk({name, "_timeout"}, 0, 1);
        repeat (4) begin @(posedge clk); #1; end
        chk({name, "_err"}, int'(bus.err), int'(e));
        chk({name, "_idle_valid"}, int'(bus.sym_valid), 0);
        chk({name, "_idle_in_ready"}, int'(bus.in_ready), 0);
        chk({name, "_left_in_queue"}, q.size(), 0);
    endtask

    task automatic run_std(input string name);
        bit e;
        pulse_clr();
        write_table();
        model_push(e);
        start();
        send_all();
        finish_check(e, name);
    endtask

    task automatic table_abc();
        clear_leaves();
        add_leaf(8'h0, 1, 8'd0);
        add_leaf(8'h2, 2, 8'd1);
        add_leaf(8'h3, 2, 8'd2);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_sym_valid"}, int'(bus.sym_valid), 0);
        chk({name, "_sym_out"},   int'(bus.sym_out), 0);
        chk({name, "_sym_len"},   int'(bus.sym_len), 0);
        chk({name, "_sym_last"},  int'(bus.sym_last), 0);
        chk({name, "_err"},       int'(bus.err), 0);
        chk({name, "_in_ready"},  int'(bus.in_ready), 0);
    endtask

    initial begin
        bit e;
        int seen;
        bus.tbl_winc = 1'b0; bus.tbl_addr = '0; bus.tbl_sym = '0; bus.tbl_len = '0;
        bus.tbl_done = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three-symbol table, single last byte 0x1A -> 0,1,2,0,0,0
        hold_low = 1'b0;
        table_abc();
        bytes = '{8'h1A};
        run_std("abc_1a");

        // Two bytes with a 5-cycle stall on the first symbol
        table_abc();
        bytes = '{8'h1A, 8'hFF};
        hold_low = 1'b1;
        pulse_clr();
        write_table();
        model_push(e);
        start();
        fork
            send_all();
            begin
                wait_sym_valid();
                repeat (5) begin @(posedge clk); #1; end
                hold_low = 1'b0;
            end
        join
        finish_check(e, "stall");

        // Single len-8 entry at 0xA5: hit with 0xA5, miss with 0x5A
        clear_leaves();
        add_leaf(8'hA5, 8, 8'd5);
        bytes = '{8'hA5};
        run_std("a5_hit");
        bytes = '{8'h5A};
        run_std("5a_miss");

        // Tail: sym7 len8 on F0..FF, sym3 "0000" len4
        clear_leaves();
        for (int i = 0; i < 16; i++) add_leaf(8'(8'hF0 + i), 8, 8'd7);
        add_leaf(8'h0, 4, 8'd3);
        bytes = '{8'h0F};
        run_std("tail_full");
        bytes = '{8'hF0};
        run_std("tail_short");

        // clr while a symbol is pending
        table_abc();
        bytes = '{8'h1A};
        hold_low = 1'b1;
        pulse_clr();
        write_table();
        model_push(e);
        start();
        send_all();
        wait_sym_valid();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
        chk("clr_sym_valid", int'(bus.sym_valid), 0);
        chk("clr_err", int'(bus.err), 0);
        chk("clr_in_ready", int'(bus.in_ready), 1);
        hold_low = 1'b0;
        // Table must now be empty: decode of any byte errors out
        clear_leaves();
        model_push(e);
        start();
        send_all();
        finish_check(e, "after_clr_empty");
        table_abc();
        run_std("after_clr_reload");

        // Asynchronous reset mid-decode
        hold_low = 1'b1;
        pulse_clr();
        write_table();
        model_push(e);
        start();
        send_all();
        wait_sym_valid();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_low = 1'b0;
        send_all();
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.sym_valid) seen++; end
        chk("no_sym_before_done", seen, 0);
        write_table();
        model_push(e);
        start();
        finish_check(e, "after_rst");

        // Random prefix codes, optional holes, random padding
        for (int t = 0; t < 40; t++) begin
            bit sb[$];
            int ns;
            clear_leaves();
            add_leaf(8'h0, 1, 8'd0);
            add_leaf(8'h1, 1, 8'd0);
            ns = $urandom_range(0, 12);
            for (int s = 0; s < ns; s++) begin
                int idx;
                logic [7:0] v;
                int l;
                idx = $urandom_range(0, lv.size() - 1);
                if (ll[idx] < 8) begin
                    v = lv[idx];
                    l = ll[idx];
                    lv[idx] = 8'(v << 1);
                    ll[idx] = l + 1;
                    add_leaf(8'((v << 1) | 8'h1), l + 1, 8'd0);
                end
            end
            foreach (ls[i]) ls[i] = 8'($urandom_range(0, 255));
            if (lv.size() > 1 && $urandom_range(0, 2) == 0) begin
                int d;
                d = $urandom_range(0, lv.size() - 1);
                lv.delete(d); ll.delete(d); ls.delete(d);
            end
            ns = $urandom_range(1, 10);
            for (int s = 0; s < ns; s++) begin
                int i;
                i = $urandom_range(0, lv.size() - 1);
                for (int b = ll[i] - 1; b >= 0; b--) sb.push_back(lv[i][b]);
            end
            while (sb.size() % 8 != 0) sb.push_back(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat (8) sb.push_back(1'($urandom_range(0, 1)));
            bytes.delete();
            for (int i = 0; i < sb.size() / 8; i++) begin
                logic [7:0] by;
                for (int j = 0; j < 8; j++) by[j] = sb[i*8+j];
                bytes.push_back(by);
            end
            run_std("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
